// File: rtl/clock_enable_arbiter.sv
// Round-robin arbiter feeding a single-entry output stage; io_en marks the load cycle on clk.
// Optional burst hold on the current source is enabled with `define ARB_LOCK_EN (adds io_lock).
module clock_enable_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     io_req,
  input  logic [N*W-1:0]   io_data,
  output logic [N-1:0]     io_grant,
  output logic             io_en,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [W-1:0]     io_out_data,
  output logic [SW-1:0]    io_out_src
`ifdef ARB_LOCK_EN
  ,
  input  logic             io_lock
`endif
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] src_q, src_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  data_q, data_d;

  logic          found_s;
  logic          locked_s;
  logic          hit_s;
  logic [SW-1:0] win_s;
  logic [W-1:0]  win_data_s;
  logic          can_load_s;
  logic          xfer_s;

  // Winner search: first requester at or above ptr, wrapping modulo N.
  always_comb begin
    int idx;
    found_s  = 1'b0;
    locked_s = 1'b0;
    hit_s    = 1'b0;
    win_s    = '0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx     = (int'(ptr_q) + k) % N;
      hit_s   = ~found_s & io_req[idx];
      win_s   = hit_s ? SW'(idx) : win_s;
      found_s = found_s | hit_s;
    end
`ifdef ARB_LOCK_EN
    locked_s = io_lock & io_req[src_q];
    win_s    = locked_s ? src_q : win_s;
    found_s  = found_s | locked_s;
`endif
    win_data_s = io_data[int'(win_s)*W +: W];
  end

  assign can_load_s = ~valid_q | io_out_ready;
  // Reset suppresses the grant so nothing transfers in the reset cycle.
  assign xfer_s     = can_load_s & found_s & ~reset;
  assign io_grant   = xfer_s ? (N'(1) << win_s) : {N{1'b0}};
  assign io_en      = xfer_s;

  // Stage next state: load on transfer, drain on ready, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (xfer_s) begin
      valid_d = 1'b1;
      data_d  = win_data_s;
      src_d   = win_s;
      ptr_d   = locked_s ? ptr_q : SW'((int'(win_s) + 1) % N);
    end else if (io_out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign io_out_valid = valid_q;
  assign io_out_data  = data_q;
  assign io_out_src   = src_q;

endmodule
